// File: rtl/wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbuf_pkg
// Description : Shared widths, default depth and FSM state type for the
//               data-memory write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package wbuf_pkg;

    localparam int LINE_W        = 128;
    localparam int LADDR_W       = 28;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_READ  = 2'd2
    } wbuf_state_e;

endpackage
`default_nettype wire

// File: rtl/wbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wbuf_fifo
// Description : Line-entry storage for the write buffer: circular FIFO with
//               registered full/empty and parallel address match returning
//               the youngest read hit and the coalesce target.
// Revision    : 1.0 - initial release
// ============================================================================
module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [LADDR_W-1:0] i_push_addr,
    input  logic [LINE_W-1:0]  i_push_data,
    input  logic               i_upd,
    input  logic [PTR_W-1:0]   i_upd_idx,
    input  logic [LINE_W-1:0]  i_upd_data,
    input  logic               i_pop,
    input  logic               i_head_busy,
    input  logic [LADDR_W-1:0] i_wr_addr,
    input  logic [LADDR_W-1:0] i_rd_addr,
    output logic [LADDR_W-1:0] o_head_addr,
    output logic [LINE_W-1:0]  o_head_data,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_coal_hit,
    output logic [PTR_W-1:0]   o_coal_idx,
    output logic               o_rd_hit,
    output logic [LINE_W-1:0]  o_rd_data
);

    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]   r_valid;
    logic [LADDR_W-1:0] r_addr [DEPTH];
    logic [LINE_W-1:0]  r_data [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_empty;

    logic [CNT_W-1:0]   w_count_next;
    logic [DEPTH-1:0]   w_rd_eq;
    logic [DEPTH-1:0]   w_wr_eq;
    logic               w_rd_hit;
    logic [PTR_W-1:0]   w_rd_idx;
    logic               w_coal_hit;
    logic [PTR_W-1:0]   w_coal_idx;

    always_comb begin
        w_count_next = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (i_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Payload needs no reset: r_valid gates every use of it.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
        end
        if (i_upd) begin
            r_data[i_upd_idx] <= i_upd_data;
        end
    end

    // The head being written to memory must never be coalesced into.
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign w_rd_eq[g] = r_valid[g] && (r_addr[g] == i_rd_addr);
        assign w_wr_eq[g] = r_valid[g] && (r_addr[g] == i_wr_addr) &&
                            !(i_head_busy && (PTR_W'(g) == r_head));
    end

    // Scan oldest to youngest so the last hit seen is the youngest.
    always_comb begin
        w_rd_hit   = 1'b0;
        w_rd_idx   = r_head;
        w_coal_hit = 1'b0;
        w_coal_idx = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_rd_eq[r_head + PTR_W'(i)]) begin
                w_rd_hit = 1'b1;
                w_rd_idx = r_head + PTR_W'(i);
            end
            if (w_wr_eq[r_head + PTR_W'(i)]) begin
                w_coal_hit = 1'b1;
                w_coal_idx = r_head + PTR_W'(i);
            end
        end
    end

    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_coal_hit  = w_coal_hit;
    assign o_coal_idx  = w_coal_idx;
    assign o_rd_hit    = w_rd_hit;
    assign o_rd_data   = r_data[w_rd_idx];

endmodule
`default_nettype wire

// File: rtl/dmem_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_write_buffer
// Description : Line write buffer between D-cache and slow data memory.
//               Absorbs writebacks, drains in background, reads have
//               priority over further drains. Define WBUF_FORWARD_EN to serve
//               read hits straight from the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_write_buffer
    import wbuf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               c_read,
    input  logic               c_write,
    input  logic [LADDR_W-1:0] c_addr,
    input  logic [LINE_W-1:0]  c_wdata,
    output logic [LINE_W-1:0]  c_rdata,
    output logic               c_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic [LADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    output logic               wb_full,
    output logic               wb_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wbuf_state_e        r_state;
    wbuf_state_e        w_state_next;
    logic               r_c_ready;
    logic [LINE_W-1:0]  r_c_rdata;
    logic [LADDR_W-1:0] r_rd_addr;

    logic               w_full;
    logic               w_empty;
    logic [LADDR_W-1:0] w_head_addr;
    logic [LINE_W-1:0]  w_head_data;
    logic               w_coal_hit;
    logic [PTR_W-1:0]   w_coal_idx;
    logic               w_rd_hit;
    logic [LINE_W-1:0]  w_rd_data;

    logic               w_rd_pending;
    logic               w_wr_accept;
    logic               w_push;
    logic               w_upd;
    logic               w_pop;
    logic               w_fwd;
    logic               w_rd_go;
    logic               w_rd_done;

    // A pulse on c_ready means the cache may still be holding its request
    // this cycle, so nothing is accepted until it has dropped.
    assign w_rd_pending = c_read && !r_c_ready;
    assign w_wr_accept  = c_write && !c_read && !r_c_ready && !w_full;
    assign w_upd        = w_wr_accept && w_coal_hit;
    assign w_push       = w_wr_accept && !w_coal_hit;
    assign w_pop        = (r_state == S_DRAIN) && mem_ready;
    assign w_rd_done    = (r_state == S_READ) && mem_ready;

`ifdef WBUF_FORWARD_EN
    assign w_fwd   = w_rd_pending && w_rd_hit;
    assign w_rd_go = w_rd_pending && !w_rd_hit;
`else
    // Without forwarding the buffer must be fully drained before a read.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_rd_hit, w_rd_data};
    assign w_fwd        = 1'b0;
    assign w_rd_go      = w_rd_pending && w_empty;
`endif

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (c_addr),
        .i_push_data (c_wdata),
        .i_upd       (w_upd),
        .i_upd_idx   (w_coal_idx),
        .i_upd_data  (c_wdata),
        .i_pop       (w_pop),
        .i_head_busy (r_state == S_DRAIN),
        .i_wr_addr   (c_addr),
        .i_rd_addr   (c_addr),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_coal_hit  (w_coal_hit),
        .o_coal_idx  (w_coal_idx),
        .o_rd_hit    (w_rd_hit),
        .o_rd_data   (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_go) begin
                    w_state_next = S_READ;
                end else if (!w_empty) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                mem_write = 1'b1;
                mem_addr  = w_head_addr;
                mem_wdata = w_head_data;
                if (mem_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            S_READ: begin
                mem_read = 1'b1;
                mem_addr = r_rd_addr;
                if (mem_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c_ready <= 1'b0;
            r_c_rdata <= '0;
            r_rd_addr <= '0;
        end else begin
            r_c_ready <= w_wr_accept || w_fwd || w_rd_done;
            if (w_fwd) begin
                r_c_rdata <= w_rd_data;
            end else if (w_rd_done) begin
                r_c_rdata <= mem_rdata;
            end
            if ((r_state == S_IDLE) && w_rd_go) begin
                r_rd_addr <= c_addr;
            end
        end
    end

    assign c_ready  = r_c_ready;
    assign c_rdata  = r_c_rdata;
    assign wb_full  = w_full;
    assign wb_empty = w_empty;

endmodule
`default_nettype wire
